isp_access_arbiter: RTL and testbench
=====================================

# isp_access_arbiter

Shares the single valid/ready register port of the ISP core between two requesters: the Wishbone slave path (read/write) and the logic-analyzer write path (write-only). It sits between the user-project bus glue and the ISP core. It grants requesters round-robin, registers each granted request onto the core port, and returns a one-cycle ready pulse to the winner. A watchdog aborts a core transaction that stalls and flags the error.

## Interface
- BITS, 16, data width of the core register port (1..32)
- TIMEOUT, 255, max cycles core_valid may stay high without core_ready (1..255)
- ERR_DATA, all-ones, rdata returned on a timed-out transaction
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid  in  1  Wishbone request (cyc & stb), held until wb_ready
- wb_wstrb  in  4  byte write strobes, 0 = read
- wb_wdata  in  BITS  Wishbone write data
- wb_ready  out  1  one-cycle completion pulse to Wishbone
- wb_rdata  out  BITS  read data, valid while wb_ready=1, else 0
- la_valid  in  1  LA write request, held until la_ready
- la_wdata  in  BITS  LA write data
- la_ready  out  1  one-cycle completion pulse to LA
- core_valid  out  1  request to ISP core
- core_wstrb  out  4  strobes to core
- core_wdata  out  BITS  write data to core
- core_ready  in  1  core completion
- core_rdata  in  BITS  core read data, valid with core_ready
- grant  out  1  current/last owner: 0 = WB, 1 = LA
- busy  out  1  high in any state other than IDLE
- err_clr  in  1  synchronous clear of timeout_err
- timeout_err  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, GNT_WB, GNT_LA, RESP.
- IDLE: if only one valid is high, grant it. If both are high, grant the requester that was not granted last (last_gnt register, reset value LA, so WB wins the first tie). If neither is high, stay in IDLE.
- On grant, register core_wdata and core_wstrb: WB uses wb_wdata and wb_wstrb; LA uses la_wdata and 4'hF. Update last_gnt and grant. Go to GNT_x.
- GNT_x: core_valid=1 and the payload is held stable.
  - core_ready=1: capture core_rdata and go to RESP.
  - Watchdog reaches TIMEOUT first: capture ERR_DATA, set timeout_err, go to RESP.
- RESP: core_valid=0. Pulse ready to the granted requester only. wb_rdata carries the captured data when WB is served; la_ready carries no data. Go to IDLE.
- A requester must drop valid in the cycle after its ready pulse. A valid still high in IDLE is treated as a new request.
- A valid that drops during GNT_x does not abort the transaction: it completes and the ready pulse is still issued.
- err_clr clears timeout_err. If err_clr and a new timeout occur in the same cycle, set wins.
- Reset (async, any state): FSM → IDLE; all outputs 0 except grant=1 (last_gnt=LA); watchdog and timeout_err cleared. An in-flight core transaction is abandoned with no ready pulse.

## Timing
- Registered outputs only; no combinational path from any input to any output.
- Request high in cycle 0 and granted → core_valid high from cycle 1.
- core_ready high in cycle k (k≥1) → ready pulse in cycle k+1, FSM back in IDLE in cycle k+2.
- Minimum request-to-ready latency is 2 cycles. Back-to-back throughput is one transaction per 3 cycles.
- Watchdog counts cycles with core_valid=1, starting at 1 in cycle 1. If the count equals TIMEOUT with core_ready=0 → RESP next cycle. core_ready in the same cycle as the timeout wins (normal completion, no error).
- The counter is 8 bits and resets on each grant. It never wraps, because it stops at TIMEOUT.

## Structure
- Package isp_arb_pkg: state enum (IDLE, GNT_WB, GNT_LA, RESP), GNT_WB=1'b0 / GNT_LA=1'b1, LA_WSTRB=4'hF.
- Sub-module isp_arb_watchdog: clear, enable, 8-bit count, expire output at TIMEOUT.
- Top holds the FSM, round-robin pointer, and payload/response registers.

## Test plan
- Single WB write (wstrb=4'h3, wdata=16'h1234), core_ready in cycle 1 → core_wdata=16'h1234 and core_wstrb=4'h3 in cycle 1, wb_ready pulse in cycle 2, la_ready=0.
- WB read, core returns 16'hBEEF after 3 wait cycles → wb_rdata=16'hBEEF exactly during the single wb_ready cycle, 0 otherwise.
- wb_valid and la_valid both held high for 4 transactions → grant sequence WB, LA, WB, LA; LA transactions show core_wstrb=4'hF.
- core_ready never asserted, TIMEOUT=8 → wb_ready in cycle 9 with wb_rdata=16'hFFFF, timeout_err=1 until err_clr, then 0.
- core_ready asserted in the exact expiry cycle → normal rdata returned, timeout_err stays 0.
- rst_n pulsed low during GNT_LA → core_valid=0 immediately, no la_ready pulse, next tie grants WB.

Source files
------------

// File: rtl/isp_arb_pkg.sv
// Shared types and constants for the ISP register-port arbiter.
package isp_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GNT_WB = 2'd1,
        S_GNT_LA = 2'd2,
        S_RESP   = 2'd3
    } arb_state_e;

    localparam logic       GNT_WB   = 1'b0;
    localparam logic       GNT_LA   = 1'b1;
    localparam logic [3:0] LA_WSTRB = 4'hF;

    // Round-robin tie-break: serve whoever did not own the port last time.
    function automatic logic pick_la(input logic wb_req, input logic la_req, input logic last_gnt);
        logic sel;
        if (la_req && wb_req) begin
            sel = (last_gnt == GNT_WB);
        end else begin
            sel = la_req;
        end
        return sel;
    endfunction

endpackage

// File: rtl/isp_arb_watchdog.sv
// Stall watchdog: counts cycles a core request is outstanding and saturates at the limit.
module isp_arb_watchdog
    import isp_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count_r;

    // Count loads 1 on grant so the first core_valid cycle is cycle 1; it stops at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd1;
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = enable && (count_r == LIMIT);

endmodule

// File: rtl/isp_access_arbiter.sv
// Round-robin arbiter sharing the ISP core register port between Wishbone and LA writers.
module isp_access_arbiter
    import isp_arb_pkg::*;
#(
    parameter int              BITS     = 16,
    parameter int              TIMEOUT  = 255,
    parameter logic [BITS-1:0] ERR_DATA = {BITS{1'b1}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic [3:0]      wb_wstrb,
    input  logic [BITS-1:0] wb_wdata,
    output logic            wb_ready,
    output logic [BITS-1:0] wb_rdata,
    input  logic            la_valid,
    input  logic [BITS-1:0] la_wdata,
    output logic            la_ready,
    output logic            core_valid,
    output logic [3:0]      core_wstrb,
    output logic [BITS-1:0] core_wdata,
    input  logic            core_ready,
    input  logic [BITS-1:0] core_rdata,
    output logic            grant,
    output logic            busy,
    input  logic            err_clr,
    output logic            timeout_err
);

    arb_state_e      state_r;
    logic            last_gnt_r;
    logic            core_valid_r;
    logic [3:0]      core_wstrb_r;
    logic [BITS-1:0] core_wdata_r;
    logic            wb_ready_r;
    logic            la_ready_r;
    logic [BITS-1:0] wb_rdata_r;
    logic            busy_r;
    logic            timeout_err_r;

    logic            in_gnt_s;
    logic            req_any_s;
    logic            pick_la_s;
    logic            wd_clear_s;
    logic            wd_expire_s;
    logic            timeout_hit_s;
    logic [BITS-1:0] rsp_data_s;

    // Request decode, watchdog control and response data selection.
    always_comb begin
        in_gnt_s      = (state_r == S_GNT_WB) || (state_r == S_GNT_LA);
        req_any_s     = wb_valid || la_valid;
        pick_la_s     = pick_la(wb_valid, la_valid, last_gnt_r);
        wd_clear_s    = (state_r == S_IDLE) && req_any_s;
        timeout_hit_s = wd_expire_s && !core_ready;
        if (core_ready) begin
            rsp_data_s = core_rdata;
        end else begin
            rsp_data_s = ERR_DATA;
        end
    end

    isp_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear_s),
        .enable (in_gnt_s),
        .expire (wd_expire_s)
    );

    // Arbitration FSM with all port-facing outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            last_gnt_r   <= GNT_LA;
            core_valid_r <= 1'b0;
            core_wstrb_r <= 4'h0;
            core_wdata_r <= {BITS{1'b0}};
            wb_ready_r   <= 1'b0;
            la_ready_r   <= 1'b0;
            wb_rdata_r   <= {BITS{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    wb_ready_r <= 1'b0;
                    la_ready_r <= 1'b0;
                    wb_rdata_r <= {BITS{1'b0}};
                    if (req_any_s) begin
                        core_valid_r <= 1'b1;
                        busy_r       <= 1'b1;
                        last_gnt_r   <= pick_la_s;
                        if (pick_la_s) begin
                            core_wstrb_r <= LA_WSTRB;
                            core_wdata_r <= la_wdata;
                            state_r      <= S_GNT_LA;
                        end else begin
                            core_wstrb_r <= wb_wstrb;
                            core_wdata_r <= wb_wdata;
                            state_r      <= S_GNT_WB;
                        end
                    end else begin
                        core_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= S_IDLE;
                    end
                end
                S_GNT_WB, S_GNT_LA: begin
                    // core_ready beats a simultaneous watchdog expiry.
                    if (core_ready || wd_expire_s) begin
                        core_valid_r <= 1'b0;
                        wb_ready_r   <= (state_r == S_GNT_WB);
                        la_ready_r   <= (state_r == S_GNT_LA);
                        if (state_r == S_GNT_WB) begin
                            wb_rdata_r <= rsp_data_s;
                        end else begin
                            wb_rdata_r <= {BITS{1'b0}};
                        end
                        state_r <= S_RESP;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_RESP: begin
                    wb_ready_r <= 1'b0;
                    la_ready_r <= 1'b0;
                    wb_rdata_r <= {BITS{1'b0}};
                    busy_r     <= 1'b0;
                    state_r    <= S_IDLE;
                end
                default: begin
                    core_valid_r <= 1'b0;
                    wb_ready_r   <= 1'b0;
                    la_ready_r   <= 1'b0;
                    wb_rdata_r   <= {BITS{1'b0}};
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky timeout flag; a new timeout outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_r <= 1'b0;
        end else if (timeout_hit_s) begin
            timeout_err_r <= 1'b1;
        end else if (err_clr) begin
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    assign core_valid  = core_valid_r;
    assign core_wstrb  = core_wstrb_r;
    assign core_wdata  = core_wdata_r;
    assign wb_ready    = wb_ready_r;
    assign la_ready    = la_ready_r;
    assign wb_rdata    = wb_rdata_r;
    assign grant       = last_gnt_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_isp_access_arbiter.sv
// Directed self-checking bench for isp_access_arbiter with a short watchdog limit.
module tb_isp_access_arbiter;

    localparam int BITS    = 16;
    localparam int TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wb_valid;
    logic [3:0]      wb_wstrb;
    logic [BITS-1:0] wb_wdata;
    logic            wb_ready;
    logic [BITS-1:0] wb_rdata;
    logic            la_valid;
    logic [BITS-1:0] la_wdata;
    logic            la_ready;
    logic            core_valid;
    logic [3:0]      core_wstrb;
    logic [BITS-1:0] core_wdata;
    logic            core_ready;
    logic [BITS-1:0] core_rdata;
    logic            grant;
    logic            busy;
    logic            err_clr;
    logic            timeout_err;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    isp_access_arbiter #(
        .BITS    (BITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_valid    (wb_valid),
        .wb_wstrb    (wb_wstrb),
        .wb_wdata    (wb_wdata),
        .wb_ready    (wb_ready),
        .wb_rdata    (wb_rdata),
        .la_valid    (la_valid),
        .la_wdata    (la_wdata),
        .la_ready    (la_ready),
        .core_valid  (core_valid),
        .core_wstrb  (core_wstrb),
        .core_wdata  (core_wdata),
        .core_ready  (core_ready),
        .core_rdata  (core_rdata),
        .grant       (grant),
        .busy        (busy),
        .err_clr     (err_clr),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        logic exp_la;
        rst_n      = 1'b0;
        wb_valid   = 1'b0;
        wb_wstrb   = 4'h0;
        wb_wdata   = 16'h0000;
        la_valid   = 1'b0;
        la_wdata   = 16'h0000;
        core_ready = 1'b0;
        core_rdata = 16'h0000;
        err_clr    = 1'b0;

        step();
        step();
        check_val("rst_core_valid", 32'(core_valid), 32'd0);
        check_val("rst_grant", 32'(grant), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_wb_ready", 32'(wb_ready), 32'd0);
        check_val("rst_la_ready", 32'(la_ready), 32'd0);
        check_val("rst_wb_rdata", 32'(wb_rdata), 32'd0);
        check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        step();

        // Both requesters held: WB, LA, WB, LA.
        wb_valid   = 1'b1;
        wb_wstrb   = 4'h5;
        wb_wdata   = 16'hA001;
        la_valid   = 1'b1;
        la_wdata   = 16'hB002;
        core_ready = 1'b1;
        core_rdata = 16'h0042;
        for (int i = 0; i < 4; i++) begin
            exp_la = (i % 2) == 1;
            step();
            check_val("rr_core_valid", 32'(core_valid), 32'd1);
            check_val("rr_grant", 32'(grant), 32'(exp_la));
            check_val("rr_wstrb", 32'(core_wstrb), exp_la ? 32'h0000000F : 32'h00000005);
            check_val("rr_wdata", 32'(core_wdata), exp_la ? 32'h0000B002 : 32'h0000A001);
            step();
            check_val("rr_wb_ready", 32'(wb_ready), 32'(!exp_la));
            check_val("rr_la_ready", 32'(la_ready), 32'(exp_la));
            check_val("rr_wb_rdata", 32'(wb_rdata), exp_la ? 32'h00000000 : 32'h00000042);
            check_val("rr_resp_busy", 32'(busy), 32'd1);
            step();
            check_val("rr_idle_busy", 32'(busy), 32'd0);
        end
        wb_valid   = 1'b0;
        la_valid   = 1'b0;
        core_ready = 1'b0;
        step();

        // Single WB write; valid drops while granted but the transaction completes.
        wb_valid = 1'b1;
        wb_wstrb = 4'h3;
        wb_wdata = 16'h1234;
        step();
        check_val("wr_core_valid", 32'(core_valid), 32'd1);
        check_val("wr_core_wdata", 32'(core_wdata), 32'h00001234);
        check_val("wr_core_wstrb", 32'(core_wstrb), 32'h00000003);
        check_val("wr_grant", 32'(grant), 32'd0);
        wb_valid   = 1'b0;
        core_ready = 1'b1;
        core_rdata = 16'h7777;
        step();
        check_val("wr_wb_ready", 32'(wb_ready), 32'd1);
        check_val("wr_la_ready", 32'(la_ready), 32'd0);
        check_val("wr_core_valid_resp", 32'(core_valid), 32'd0);
        core_ready = 1'b0;
        step();
        check_val("wr_wb_ready_done", 32'(wb_ready), 32'd0);
        check_val("wr_busy_done", 32'(busy), 32'd0);

        // WB read with three wait cycles.
        wb_valid = 1'b1;
        wb_wstrb = 4'h0;
        for (int c = 1; c <= 3; c++) begin
            step();
            check_val("rd_wait_ready", 32'(wb_ready), 32'd0);
            check_val("rd_wait_rdata", 32'(wb_rdata), 32'd0);
        end
        step();
        core_ready = 1'b1;
        core_rdata = 16'hBEEF;
        step();
        check_val("rd_wb_ready", 32'(wb_ready), 32'd1);
        check_val("rd_wb_rdata", 32'(wb_rdata), 32'h0000BEEF);
        wb_valid   = 1'b0;
        core_ready = 1'b0;
        step();
        check_val("rd_ready_after", 32'(wb_ready), 32'd0);
        check_val("rd_rdata_after", 32'(wb_rdata), 32'd0);

        // Watchdog expiry with no core_ready.
        wb_valid = 1'b1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            step();
            check_val("to_core_valid", 32'(core_valid), 32'd1);
            check_val("to_wb_ready_wait", 32'(wb_ready), 32'd0);
        end
        step();
        check_val("to_wb_ready", 32'(wb_ready), 32'd1);
        check_val("to_wb_rdata", 32'(wb_rdata), 32'h0000FFFF);
        check_val("to_err_set", 32'(timeout_err), 32'd1);
        check_val("to_core_valid_off", 32'(core_valid), 32'd0);
        wb_valid = 1'b0;
        step();
        check_val("to_err_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_val("to_err_cleared", 32'(timeout_err), 32'd0);

        // core_ready in the exact expiry cycle wins over the watchdog.
        wb_valid = 1'b1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            step();
        end
        core_ready = 1'b1;
        core_rdata = 16'h5A5A;
        step();
        check_val("edge_wb_ready", 32'(wb_ready), 32'd1);
        check_val("edge_wb_rdata", 32'(wb_rdata), 32'h00005A5A);
        check_val("edge_no_err", 32'(timeout_err), 32'd0);
        wb_valid   = 1'b0;
        core_ready = 1'b0;
        step();

        // Reset while LA owns the core port.
        la_valid = 1'b1;
        la_wdata = 16'hCAFE;
        step();
        check_val("rl_grant", 32'(grant), 32'd1);
        check_val("rl_core_valid", 32'(core_valid), 32'd1);
        check_val("rl_core_wstrb", 32'(core_wstrb), 32'h0000000F);
        check_val("rl_core_wdata", 32'(core_wdata), 32'h0000CAFE);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rl_async_core_valid", 32'(core_valid), 32'd0);
        check_val("rl_async_busy", 32'(busy), 32'd0);
        la_valid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("rl_no_la_ready", 32'(la_ready), 32'd0);
        end
        wb_valid = 1'b1;
        la_valid = 1'b1;
        wb_wstrb = 4'h5;
        step();
        check_val("rl_tie_grant_wb", 32'(grant), 32'd0);
        check_val("rl_tie_core_valid", 32'(core_valid), 32'd1);
        wb_valid   = 1'b0;
        la_valid   = 1'b0;
        core_ready = 1'b1;
        step();
        check_val("rl_tie_wb_ready", 32'(wb_ready), 32'd1);
        core_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
